instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 34 +++
 rtl/instr_fetch_buffer.sv | 45 ++++
 rtl/instr_fetch.sv | 80 ++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared widths, instruction-word field positions and buffer sizing for the
// instruction fetch unit.
package instr_fetch_pkg;

    localparam int DATA_WIDTH        = 8;
    localparam int ADDR_WIDTH        = 12;
    localparam int INSTRUCTION_WIDTH = 16;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 8;
    localparam int ARG_MSB    = 7;
    localparam int ARG_LSB    = 0;

    localparam int BUF_DEPTH   = 2;
    localparam int COUNT_WIDTH = 2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] opcode;
        logic [DATA_WIDTH-1:0] arg;
        logic [ADDR_WIDTH-1:0] addr;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(
        input logic [INSTRUCTION_WIDTH-1:0] word,
        input logic [ADDR_WIDTH-1:0]        addr
    );
        fetch_entry_t e;
        e.opcode = word[OPCODE_MSB:OPCODE_LSB];
        e.arg    = word[ARG_MSB:ARG_LSB];
        e.addr   = addr;
        return e;
    endfunction

endpackage

// File: rtl/instr_fetch_buffer.sv
// Two-entry instruction FIFO; flush empties it and takes precedence over
// any push or pop in the same cycle.
module fetch_buffer
    import instr_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           push_entry,
    output fetch_entry_t           head_entry,
    output logic [COUNT_WIDTH-1:0] count
);

    fetch_entry_t entries [BUF_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);
        end
    end

    // Payload storage needs no reset; it is only observed while count != 0.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            entries[wr_ptr] <= push_entry;
        end
    end

    assign head_entry = entries[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues program-memory reads, buffers up to two
// returned instructions and hands them to the control unit with valid/ready.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDR_WIDTH-1:0]        MEM_ADDR,
    output logic                         MEM_RD,
    input  logic [INSTRUCTION_WIDTH-1:0] MEM_DATA_IN,
    output logic [DATA_WIDTH-1:0]        INSTR_OUT,
    output logic [DATA_WIDTH-1:0]        ARG_OUT,
    output logic [ADDR_WIDTH-1:0]        PC_OUT,
    output logic                         INSTR_VALID,
    input  logic                         INSTR_READY,
    input  logic                         JUMP_EN,
    input  logic [ADDR_WIDTH-1:0]        JUMP_ADDR
);

    // Handshake: a head instruction moves to the control unit on every rising
    // edge where INSTR_VALID and INSTR_READY are both 1; the head stays stable
    // otherwise. Memory reads return data exactly one cycle after MEM_RD.

    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [ADDR_WIDTH-1:0]  flight_addr;
    logic                   in_flight;
    logic                   squash;
    logic                   pop;
    logic                   push;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH:0]   pending;
    fetch_entry_t           head_entry;
    fetch_entry_t           push_entry;

    fetch_buffer u_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (JUMP_EN),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .count      (count)
    );

    always_comb begin
        INSTR_VALID = !reset && (count != '0);
        pop         = INSTR_VALID && INSTR_READY;
        // Slots already claimed once this cycle's pop is accounted for.
        pending     = (COUNT_WIDTH+1)'(count) + (COUNT_WIDTH+1)'(in_flight)
                      - (COUNT_WIDTH+1)'(pop);
        MEM_RD      = !reset && !JUMP_EN && (pending < (COUNT_WIDTH+1)'(BUF_DEPTH));
        MEM_ADDR    = reset ? '0 : fetch_pc;
        // A response arriving in a redirect cycle belongs to the old stream.
        push        = in_flight && !squash && !JUMP_EN;
        push_entry  = make_entry(MEM_DATA_IN, flight_addr);
        INSTR_OUT   = INSTR_VALID ? head_entry.opcode : '0;
        ARG_OUT     = INSTR_VALID ? head_entry.arg    : '0;
        PC_OUT      = INSTR_VALID ? head_entry.addr   : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= '0;
            flight_addr <= '0;
            in_flight   <= 1'b0;
            squash      <= 1'b0;
        end else begin
            in_flight <= MEM_RD;
            squash    <= JUMP_EN && in_flight;
            if (JUMP_EN) begin
                fetch_pc <= JUMP_ADDR;
            end else if (MEM_RD) begin
                flight_addr <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_WIDTH'(1);
            end
        end
    end

endmodule
